// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : RISC-V memory-stage control with dmem req/ack handshake, stall
//            generation and M->W register. Optional macro MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic            MemWriteM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] PCPlus4M,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            StallM,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] PCPlus4W,
    output logic            MemErr
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] C_SRC_LOAD = 2'b01;

    state_t            state_q, state_d;

    logic              hold_we_q, hold_we_d;
    logic [XLEN-1:0]   hold_addr_q, hold_addr_d;
    logic [XLEN-1:0]   hold_wdata_q, hold_wdata_d;
    logic              hold_regwrite_q, hold_regwrite_d;
    logic [1:0]        hold_src_q, hold_src_d;
    logic [4:0]        hold_rd_q, hold_rd_d;
    logic [XLEN-1:0]   hold_pc4_q, hold_pc4_d;

    logic              regwrite_w_q, regwrite_w_d;
    logic [1:0]        src_w_q, src_w_d;
    logic [XLEN-1:0]   alu_w_q, alu_w_d;
    logic [XLEN-1:0]   rdata_w_q, rdata_w_d;
    logic [4:0]        rd_w_q, rd_w_d;
    logic [XLEN-1:0]   pc4_w_q, pc4_w_d;

    logic              w_memop;
    logic              w_in_wait;
    logic              w_req;
    logic              w_done;
    logic              w_stall;
    logic              w_abort;
    logic              w_sel_regwrite;
    logic [1:0]        w_sel_src;
    logic [XLEN-1:0]   w_sel_alu;
    logic [4:0]        w_sel_rd;
    logic [XLEN-1:0]   w_sel_pc4;

    assign w_memop   = MemWriteM | (ResultSrcM == C_SRC_LOAD);
    assign w_in_wait = (state_q == S_WAIT);
    // Gated by reset so a memop held at the M inputs cannot request during reset.
    assign w_req     = reset & (w_in_wait | ((state_q == S_IDLE) & w_memop));
    assign w_done    = w_req & dmem_ack;
    assign w_stall   = w_req & ~dmem_ack;

    assign w_sel_regwrite = w_in_wait ? hold_regwrite_q : RegWriteM;
    assign w_sel_src      = w_in_wait ? hold_src_q      : ResultSrcM;
    assign w_sel_alu      = w_in_wait ? hold_addr_q     : ALUResultM;
    assign w_sel_rd       = w_in_wait ? hold_rd_q       : RdM;
    assign w_sel_pc4      = w_in_wait ? hold_pc4_q      : PCPlus4M;

    assign dmem_req   = w_req;
    assign dmem_we    = w_in_wait ? hold_we_q    : MemWriteM;
    assign dmem_addr  = w_in_wait ? hold_addr_q  : ALUResultM;
    assign dmem_wdata = w_in_wait ? hold_wdata_q : WriteDataM;
    assign StallM     = w_stall;

    assign RegWriteW  = regwrite_w_q;
    assign ResultSrcW = src_w_q;
    assign ALUResultW = alu_w_q;
    assign ReadDataW  = rdata_w_q;
    assign RdW        = rd_w_q;
    assign PCPlus4W   = pc4_w_q;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       memerr_q;

    // Held at zero in IDLE so every WAIT entry starts counting from zero.
    always_comb begin
        cnt_d = '0;
        if (w_in_wait) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign w_abort = w_in_wait & ~dmem_ack & (cnt_q == C_TIMEOUT_LAST);
    assign MemErr  = memerr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            memerr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            memerr_q <= w_abort;
        end
    end
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT);
    assign w_abort          = 1'b0;
    assign MemErr           = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        hold_we_d       = hold_we_q;
        hold_addr_d     = hold_addr_q;
        hold_wdata_d    = hold_wdata_q;
        hold_regwrite_d = hold_regwrite_q;
        hold_src_d      = hold_src_q;
        hold_rd_d       = hold_rd_q;
        hold_pc4_d      = hold_pc4_q;

        case (state_q)
            S_IDLE: begin
                if (w_memop) begin
                    hold_we_d       = MemWriteM;
                    hold_addr_d     = ALUResultM;
                    hold_wdata_d    = WriteDataM;
                    hold_regwrite_d = RegWriteM;
                    hold_src_d      = ResultSrcM;
                    hold_rd_d       = RdM;
                    hold_pc4_d      = PCPlus4M;
                    if (!dmem_ack) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ack || w_abort) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The abort cycle is itself a stall cycle, which supplies the W bubble.
    always_comb begin
        regwrite_w_d = regwrite_w_q;
        src_w_d      = src_w_q;
        alu_w_d      = alu_w_q;
        rdata_w_d    = rdata_w_q;
        rd_w_d       = rd_w_q;
        pc4_w_d      = pc4_w_q;

        if (w_done) begin
            regwrite_w_d = w_sel_regwrite;
            src_w_d      = w_sel_src;
            alu_w_d      = w_sel_alu;
            rd_w_d       = w_sel_rd;
            pc4_w_d      = w_sel_pc4;
            if (w_sel_src == C_SRC_LOAD) begin
                rdata_w_d = dmem_rdata;
            end
        end else if (w_stall) begin
            regwrite_w_d = 1'b0;
            src_w_d      = 2'b00;
        end else begin
            regwrite_w_d = RegWriteM;
            src_w_d      = ResultSrcM;
            alu_w_d      = ALUResultM;
            rd_w_d       = RdM;
            pc4_w_d      = PCPlus4M;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            hold_we_q       <= 1'b0;
            hold_addr_q     <= '0;
            hold_wdata_q    <= '0;
            hold_regwrite_q <= 1'b0;
            hold_src_q      <= 2'b00;
            hold_rd_q       <= '0;
            hold_pc4_q      <= '0;
            regwrite_w_q    <= 1'b0;
            src_w_q         <= 2'b00;
            alu_w_q         <= '0;
            rdata_w_q       <= '0;
            rd_w_q          <= '0;
            pc4_w_q         <= '0;
        end else begin
            state_q         <= state_d;
            hold_we_q       <= hold_we_d;
            hold_addr_q     <= hold_addr_d;
            hold_wdata_q    <= hold_wdata_d;
            hold_regwrite_q <= hold_regwrite_d;
            hold_src_q      <= hold_src_d;
            hold_rd_q       <= hold_rd_d;
            hold_pc4_q      <= hold_pc4_d;
            regwrite_w_q    <= regwrite_w_d;
            src_w_q         <= src_w_d;
            alu_w_q         <= alu_w_d;
            rdata_w_q       <= rdata_w_d;
            rd_w_q          <= rd_w_d;
            pc4_w_q         <= pc4_w_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage control block of the pipelined RISC-V core; sits downstream of the E->M pipeline register.
- Consumes the M-stage control signals (RegWriteM, ResultSrcM, MemWriteM) and the associated data.
- Runs a req/ack handshake with data memory and stalls the pipeline while an access is outstanding.
- Drives the M->W pipeline register, inserting a bubble on every stall cycle.

Parameters:
- XLEN, 32, datapath/address width
- TIMEOUT, 16, max WAIT cycles before abort (used only with MEM_TIMEOUT_EN; legal range 2..255)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- RegWriteM  in  1  M-stage register-write enable
- ResultSrcM  in  2  result select; 2'b01 = load
- MemWriteM  in  1  M-stage store enable
- ALUResultM  in  XLEN  memory address / ALU result
- WriteDataM  in  XLEN  store data
- RdM  in  5  destination register
- PCPlus4M  in  XLEN  PC+4
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  XLEN  request address
- dmem_wdata  out  XLEN  request write data
- dmem_ack  in  1  access complete, valid one cycle
- dmem_rdata  in  XLEN  read data, valid with dmem_ack
- StallM  out  1  hold F/D/E/M stages
- RegWriteW  out  1  registered W-stage write enable
- ResultSrcW  out  2  registered W-stage result select
- ALUResultW  out  XLEN  registered ALU result
- ReadDataW  out  XLEN  registered load data
- RdW  out  5  registered destination register
- PCPlus4W  out  XLEN  registered PC+4
- MemErr  out  1  one-cycle pulse on access timeout

Behaviour:
- memop = MemWriteM | (ResultSrcM == 2'b01).
- FSM states:
  - IDLE:
    - If memop: drive dmem_req=1 combinationally; dmem_we=MemWriteM, dmem_addr=ALUResultM, dmem_wdata=WriteDataM.
    - In the same cycle, capture the request fields and the M controls/data into internal hold registers.
    - If dmem_ack is high in that same cycle: zero-wait completion, stay IDLE. Otherwise go to WAIT.
  - WAIT:
    - dmem_req=1; request outputs driven from the hold registers, stable until ack.
    - On dmem_ack, return to IDLE.
- StallM = dmem_req & ~dmem_ack (combinational).
- W register update, every clock edge:
  - Completion cycle (dmem_ack & dmem_req): load held/current M fields; ReadDataW = dmem_rdata for loads, unchanged for stores.
  - Cycles with StallM=1: bubble, i.e. RegWriteW=0 and ResultSrcW=2'b00; other W fields hold.
  - Otherwise (non-memop): W fields load directly from the M inputs; ReadDataW holds.
- Latency: load/store adds exactly N stall cycles when ack arrives N cycles after the req rises; N=0 means no stall.
- dmem_ack while dmem_req=0 is ignored and does not change state.
- A new memop in the cycle after completion starts a new request immediately, with no idle gap.
- Reset (asynchronous):
  - State goes to IDLE; dmem_req, StallM and MemErr go to 0.
  - All W outputs and hold registers clear to 0.
  - Reset in WAIT abandons the access; any later ack is ignored.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on WAIT entry and increments each WAIT cycle.
  - When the count reaches TIMEOUT-1 with no ack: dmem_req and StallM drop next cycle, FSM returns to IDLE, the W stage receives a bubble, and MemErr pulses for 1 cycle.
  - If ack and timeout occur in the same cycle, ack wins: normal completion, no MemErr.
- Undefined: WAIT persists indefinitely; the counter is absent; MemErr is tied to 0.

Test Plan:
- Zero-wait load: ResultSrcM=01, ALUResultM=0x100, ack same cycle with rdata=0xDEADBEEF -> StallM never 1; next edge RegWriteW=1, ReadDataW=0xDEADBEEF, RdW=RdM.
- 3-wait store: MemWriteM=1, addr=0x200, wdata=0x12345678, ack 3 cycles after req -> StallM=1 for 3 cycles; dmem_addr/wdata/we stable throughout; W gets bubbles (RegWriteW=0), then captures the store fields.
- ALU op stream: memop=0, RegWriteM=1, five varying ALUResultM values -> W mirrors each one a cycle later, no stalls, dmem_req=0.
- Reset mid-WAIT: reset=0 during the 2nd wait cycle -> dmem_req, StallM and all W outputs go 0 immediately; a later ack has no effect.
- Back-to-back load then store: ack latencies 1 and 0 -> req stays high across the boundary; StallM pattern 1,0,0; ReadDataW updated only for the load.
- MEM_TIMEOUT_EN defined, TIMEOUT=16, ack never arrives -> MemErr pulses once, StallM deasserts, RegWriteW=0. Repeat with ack on the final counted cycle -> normal completion, MemErr=0.
